// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the sequencer state encoding and the zero-register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IRQ_DRAIN = 2'd1,
    IRQ_ENTER = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if;
  import hazard_pkg::*;

  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic       ID_isJump;
  logic       EX_MemRd;
  logic [4:0] EX_Rt;
  logic       EX_isBranch;
  logic       EX_BranchTaken;
  logic       MemBusy;
  logic       IRQ;
  logic       IRQ_Return;

  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       Pipe_Hold;
  logic       IRQ_Take;
  logic       IRQ_Redirect;

  modport master (
    output ID_Rs, ID_Rt,
    output ID_UsesRs, ID_UsesRt,
    output ID_isJump, EX_MemRd,
    output EX_Rt, EX_isBranch,
    output EX_BranchTaken, MemBusy,
    output IRQ, IRQ_Return,
    input  PC_Write, IF_ID_Write,
    input  IF_ID_Flush, ID_EX_Flush,
    input  Pipe_Hold, IRQ_Take,
    input  IRQ_Redirect
  );

  modport slave (
    input  ID_Rs, ID_Rt,
    input  ID_UsesRs, ID_UsesRt,
    input  ID_isJump, EX_MemRd,
    input  EX_Rt, EX_isBranch,
    input  EX_BranchTaken, MemBusy,
    input  IRQ, IRQ_Return,
    output PC_Write, IF_ID_Write,
    output IF_ID_Flush, ID_EX_Flush,
    output Pipe_Hold, IRQ_Take,
    output IRQ_Redirect
  );

endinterface

// File: rtl/hazard_load_use_cmp.sv
// Combinational load-use detector; shared with the forwarding unit.
// A load into $zero never creates a dependency.
module hazard_load_use_cmp
  import hazard_pkg::*;
(
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  output logic       hit
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = uses_rs && (id_rs == ex_rt);
  assign rt_hit = uses_rt && (id_rt == ex_rt);

  assign hit = ex_mem_rd
            && (ex_rt != REG_ZERO)
            && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/IRQ-entry sequencer for the 5-stage pipeline.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int IRQ_DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  localparam int CW = $clog2(IRQ_DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DCNT_LOAD =
    CW'(IRQ_DRAIN_CYCLES - 1);

  state_t        state;
  state_t        state_n;
  logic          irq_mask;
  logic          mask_n;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] dcnt_n;
  logic          load_use;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic pipe_hold;
  logic irq_take;
  logic irq_redirect;

  hazard_load_use_cmp u_lu (
    .ex_mem_rd (hz.EX_MemRd),
    .ex_rt     (hz.EX_Rt),
    .id_rs     (hz.ID_Rs),
    .id_rt     (hz.ID_Rt),
    .uses_rs   (hz.ID_UsesRs),
    .uses_rt   (hz.ID_UsesRt),
    .hit       (load_use)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      irq_mask <= 1'b0;
      dcnt     <= '0;
    end else begin
      state    <= state_n;
      irq_mask <= mask_n;
      dcnt     <= dcnt_n;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_hold    = 1'b0;
    irq_take     = 1'b0;
    irq_redirect = 1'b0;
    state_n      = state;
    mask_n       = irq_mask;
    dcnt_n       = dcnt;

    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hz.MemBusy) begin
      // whole pipe frozen, sequencer state included
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else begin
      if (hz.IRQ_Return)
        mask_n = 1'b0;
      unique case (state)
        RUN: begin
          if (hz.EX_BranchTaken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (hz.ID_isJump) begin
            if_id_flush = 1'b1;
          end else if (hz.IRQ && !irq_mask
                       && !hz.EX_isBranch) begin
            irq_take    = 1'b1;
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            dcnt_n      = DCNT_LOAD;
            state_n     = IRQ_DRAIN;
          end
        end
        IRQ_DRAIN: begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (dcnt == '0)
            state_n = IRQ_ENTER;
          else
            dcnt_n = dcnt - 1'b1;
        end
        IRQ_ENTER: begin
          irq_redirect = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          mask_n       = 1'b1;
          state_n      = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign hz.PC_Write     = pc_write;
  assign hz.IF_ID_Write  = if_id_write;
  assign hz.IF_ID_Flush  = if_id_flush;
  assign hz.ID_EX_Flush  = id_ex_flush;
  assign hz.Pipe_Hold    = pipe_hold;
  assign hz.IRQ_Take     = irq_take;
  assign hz.IRQ_Redirect = irq_redirect;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_ev;
  logic flush_ev;

  assign stall_ev = reset && (hz.MemBusy
    || (state == RUN && load_use
        && !hz.EX_BranchTaken));
  assign flush_ev = reset && (state == RUN)
    && if_id_flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_ev)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
